// File: rtl/ms6205_pkg.sv
// Shared constants and types for the MS6205 character-display bus path.
package ms6205_pkg;
  localparam int MS6205_COLUMNS = 16;
  localparam int MS6205_ROWS    = 10;
  localparam int MS6205_MAX_POS = 160;

  typedef logic [7:0] ms6205_pos_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_SETUP,
    ST_ADDR_STROBE,
    ST_ADDR_HOLD,
    ST_DATA_SETUP,
    ST_DATA_STROBE,
    ST_DATA_HOLD
  } ms6205_bus_state_t;

  typedef struct packed {
    ms6205_pos_t pos;
    logic [7:0]  code;
  } ms6205_req_t;
endpackage

// File: rtl/ms6205_shadow_ram.sv
// Shadow of the displayed screen plus per-cell dirty bits; a refresh request
// overrides a same-cycle dirty clear so a pending full redraw is never lost.
module ms6205_shadow_ram
  import ms6205_pkg::*;
#(
  parameter int MAX_POS = MS6205_MAX_POS
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [7:0]  rd_pos,
  output logic [7:0]  rd_code,
  output logic        rd_dirty,
  input  logic        wr_en,
  input  logic        clr_dirty,
  input  logic [7:0]  wr_pos,
  input  logic [7:0]  wr_code,
  input  logic        set_all_dirty
);
  localparam ms6205_pos_t MAX_P = ms6205_pos_t'(MAX_POS);

  logic [7:0]         mem_q [MAX_POS];
  logic [MAX_POS-1:0] dirty_q, dirty_d;
  logic               rd_ok, wr_ok;

  assign rd_ok    = rd_pos < MAX_P;
  assign wr_ok    = wr_pos < MAX_P;
  assign rd_code  = rd_ok ? mem_q[rd_pos] : 8'h00;
  assign rd_dirty = rd_ok ? dirty_q[rd_pos] : 1'b1;

  // Contents are deliberately unreset: every cell starts dirty.
  always_ff @(posedge Clk) begin
    if (wr_en && wr_ok) mem_q[wr_pos] <= wr_code;
  end

  always_comb begin
    dirty_d = dirty_q;
    if (clr_dirty && wr_ok) dirty_d[wr_pos] = 1'b0;
    if (set_all_dirty) dirty_d = '1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) dirty_q <= '1;
    else        dirty_q <= dirty_d;
  end
endmodule

// File: rtl/ms6205_bus_writer.sv
// Drives the MS6205 address/data latches with timed setup/strobe/hold phases,
// skipping cells whose shadow copy already matches.
module ms6205_bus_writer
  import ms6205_pkg::*;
#(
  parameter int MAX_POS    = MS6205_MAX_POS,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic [7:0]  char_pos,
  input  logic [7:0]  char_code,
  input  logic        force_refresh,
  output logic [7:0]  ms_addr,
  output logic [7:0]  ms_data_n,
  output logic        ms_addr_wr,
  output logic        ms_data_wr,
  output logic        busy,
  output logic [15:0] skip_count,
  output logic        pos_err
);
  localparam ms6205_pos_t MAX_P = ms6205_pos_t'(MAX_POS);

  ms6205_bus_state_t state_q, state_d;
  ms6205_req_t       req_q, req_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [15:0]       skip_q, skip_d;
  logic              pos_err_q, pos_err_d;
  logic              aw_q, aw_d, dw_q, dw_d;
  logic [7:0]        sh_code;
  logic              sh_dirty, accept, pos_ok, hit, start, last, done;

  function automatic logic [7:0] stage_len(ms6205_bus_state_t s);
    case (s)
      ST_ADDR_SETUP,  ST_DATA_SETUP:  stage_len = 8'(SETUP_CYC - 1);
      ST_ADDR_STROBE, ST_DATA_STROBE: stage_len = 8'(STROBE_CYC - 1);
      ST_ADDR_HOLD,   ST_DATA_HOLD:   stage_len = 8'(HOLD_CYC - 1);
      default:                        stage_len = 8'd0;
    endcase
  endfunction

  assign accept = char_valid && (state_q == ST_IDLE);
  assign pos_ok = char_pos < MAX_P;
  assign hit    = pos_ok && (sh_code == char_code) && !sh_dirty;
  assign start  = accept && pos_ok && !hit;
  assign last   = (cnt_q == 8'd0);
  assign done   = (state_q == ST_DATA_HOLD) && last;

  ms6205_shadow_ram #(.MAX_POS(MAX_POS)) u_shadow (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .rd_pos       (char_pos),
    .rd_code      (sh_code),
    .rd_dirty     (sh_dirty),
    .wr_en        (done),
    .clr_dirty    (done),
    .wr_pos       (req_q.pos),
    .wr_code      (req_q.code),
    .set_all_dirty(force_refresh)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      req_q     <= '0;
      skip_q    <= 16'd0;
      pos_err_q <= 1'b0;
      aw_q      <= 1'b0;
      dw_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      skip_q    <= skip_d;
      pos_err_q <= pos_err_d;
      aw_q      <= aw_d;
      dw_q      <= dw_d;
    end
  end

  // Each timed state counts down from its length-1; the counter reloads on entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:        if (start) state_d = ST_ADDR_SETUP;
      ST_ADDR_SETUP:  if (last)  state_d = ST_ADDR_STROBE;
      ST_ADDR_STROBE: if (last)  state_d = ST_ADDR_HOLD;
      ST_ADDR_HOLD:   if (last)  state_d = ST_DATA_SETUP;
      ST_DATA_SETUP:  if (last)  state_d = ST_DATA_STROBE;
      ST_DATA_STROBE: if (last)  state_d = ST_DATA_HOLD;
      ST_DATA_HOLD:   if (last)  state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
    if (state_d != state_q)      cnt_d = stage_len(state_d);
    else if (state_q != ST_IDLE) cnt_d = cnt_q - 8'd1;
  end

  always_comb begin
    req_d     = req_q;
    skip_d    = skip_q;
    pos_err_d = pos_err_q;
    if (accept) begin
      if (!pos_ok)  pos_err_d = 1'b1;
      else if (hit) skip_d    = skip_q + 16'd1;
      else          req_d     = '{pos: char_pos, code: char_code};
    end
    // Strobes come from the next state so they leave a flop clean.
    aw_d = (state_d == ST_ADDR_STROBE);
    dw_d = (state_d == ST_DATA_STROBE);
  end

  assign char_ready = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign ms_addr    = req_q.pos;
  assign ms_data_n  = ~req_q.code;
  assign ms_addr_wr = aw_q;
  assign ms_data_wr = dw_q;
  assign skip_count = skip_q;
  assign pos_err    = pos_err_q;
endmodule
